// File: rtl/ddr3_partial_wr_shaper_if.sv
// ---------------------------------------------------------------------------
// ddr3_partial_wr_shaper_if
// Write-data bus bundle for the DFI partial-write shaper.
//   seq_*  : sequencer -> shaper  (enable, data, byte mask; 1 = masked)
//   dfi_*  : shaper -> PHY        (enable, data, byte mask; 1 = masked)
// Modports: master = sequencer/PHY side (testbench), slave = shaper.
// ---------------------------------------------------------------------------
interface ddr3_partial_wr_shaper_if #(
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  logic              seq_wrdata_en_i;
  logic [DATA_W-1:0] seq_wrdata_i;
  logic [MASK_W-1:0] seq_wrdata_mask_i;
  logic              dfi_wrdata_en_o;
  logic [DATA_W-1:0] dfi_wrdata_o;
  logic [MASK_W-1:0] dfi_wrdata_mask_o;

  modport master (
    output seq_wrdata_en_i, seq_wrdata_i, seq_wrdata_mask_i,
    input  dfi_wrdata_en_o, dfi_wrdata_o, dfi_wrdata_mask_o
  );

  modport slave (
    input  seq_wrdata_en_i, seq_wrdata_i, seq_wrdata_mask_i,
    output dfi_wrdata_en_o, dfi_wrdata_o, dfi_wrdata_mask_o
  );
endinterface

// File: rtl/ddr3_partial_wr_shaper.sv
// ---------------------------------------------------------------------------
// ddr3_partial_wr_shaper
// Registered DFI write-data shaper. Tracks the beat index inside each write
// burst and forces byte masks on beats that are not kept (head / window /
// bitmap modes). Enable, data and mask leave together one clock after entry.
//
// Ports
//   clk_i, rst_i     clock, async active-high reset
//   cfg_*            mode/start/len/bitmap, sampled at each burst start
//   bus (slave)      seq_* in, dfi_* out (see ddr3_partial_wr_shaper_if)
//   busy_o           high on the output cycle of every burst beat
//   burst_done_o     pulse with the last output beat of a burst
//   stat_clr_i       sync clear of the statistics counters
//   stat_bursts_o    completed bursts (saturating)
//   stat_masked_o    output beats force-masked (saturating)
//
// Build option: define PARTIAL_WR_STATS_EN to build the statistics counters;
// otherwise stat_*_o are tied to 0 and stat_clr_i is ignored.
// ---------------------------------------------------------------------------
module ddr3_partial_wr_shaper #(
  parameter  int DATA_W    = 32,
  parameter  int MAX_BEATS = 8,
  parameter  int CNT_W     = 16,
  localparam int MASK_W    = DATA_W / 8,
  localparam int BEAT_W    = $clog2(MAX_BEATS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [1:0]            cfg_mode_i,
  input  logic [BEAT_W-1:0]     cfg_start_i,
  input  logic [BEAT_W:0]       cfg_len_i,
  input  logic [MAX_BEATS-1:0]  cfg_bitmap_i,
  ddr3_partial_wr_shaper_if.slave bus,
  output logic                  busy_o,
  output logic                  burst_done_o,
  input  logic                  stat_clr_i,
  output logic [CNT_W-1:0]      stat_bursts_o,
  output logic [CNT_W-1:0]      stat_masked_o
);

  typedef enum logic {S_IDLE, S_BURST} state_e;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);

  state_e                state_q, state_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  start_burst;

  // Shadow config, captured at burst start
  logic [1:0]            mode_q;
  logic [BEAT_W-1:0]     start_q;
  logic [BEAT_W:0]       len_q;
  logic [MAX_BEATS-1:0]  bmp_q;

  // Config in effect for the beat entering this cycle
  logic [1:0]            mode_e;
  logic [BEAT_W-1:0]     start_e;
  logic [BEAT_W:0]       len_e;
  logic [MAX_BEATS-1:0]  bmp_e;
  logic [BEAT_W+1:0]     win_end;
  logic                  keep;

  logic                  out_en_q, out_last_q;
  logic [DATA_W-1:0]     out_data_q;
  logic [MASK_W-1:0]     out_mask_q;

  // Next-state / beat tracking. A full burst rolls straight into a new one
  // when enable stays high past the last beat.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    start_burst = 1'b0;
    if (bus.seq_wrdata_en_i) begin
      state_d = S_BURST;
      if (state_q == S_IDLE || beat_q == LAST_BEAT) begin
        start_burst = 1'b1;
        beat_d      = '0;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end else begin
      state_d = S_IDLE;
      beat_d  = '0;
    end
  end

  // The first beat of a burst must already see the new config, so it is
  // taken from the inputs directly in the same cycle it is latched.
  always_comb begin
    mode_e  = start_burst ? cfg_mode_i   : mode_q;
    start_e = start_burst ? cfg_start_i  : start_q;
    len_e   = start_burst ? cfg_len_i    : len_q;
    bmp_e   = start_burst ? cfg_bitmap_i : bmp_q;
    // Wide sum so start+len never wraps: window is clipped at the last beat.
    win_end = {2'b00, start_e} + {1'b0, len_e};
    keep    = 1'b1;
    case (mode_e)
      2'd1:    keep = ({1'b0, beat_d} < len_e);
      2'd2:    keep = (beat_d >= start_e) && ({2'b00, beat_d} < win_end);
      2'd3:    keep = bmp_e[beat_d];
      default: keep = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      mode_q     <= 2'd0;
      start_q    <= '0;
      len_q      <= '0;
      bmp_q      <= '0;
      out_en_q   <= 1'b0;
      out_last_q <= 1'b0;
      out_data_q <= '0;
      out_mask_q <= '1;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      if (start_burst) begin
        mode_q  <= cfg_mode_i;
        start_q <= cfg_start_i;
        len_q   <= cfg_len_i;
        bmp_q   <= cfg_bitmap_i;
      end
      out_en_q   <= bus.seq_wrdata_en_i;
      out_last_q <= bus.seq_wrdata_en_i && (beat_d == LAST_BEAT);
      out_data_q <= bus.seq_wrdata_i;
      out_mask_q <= bus.seq_wrdata_en_i ? (bus.seq_wrdata_mask_i | {MASK_W{~keep}})
                                        : '1;
    end
  end

  assign bus.dfi_wrdata_en_o   = out_en_q;
  assign bus.dfi_wrdata_o      = out_data_q;
  assign bus.dfi_wrdata_mask_o = out_mask_q;
  assign busy_o                = out_en_q;
  // A full burst is known to end from the registered beat index. A short
  // burst only ends once enable drops, which is visible on the input in the
  // same cycle the last beat is presented, so that term is combinational.
  assign burst_done_o = out_en_q && (out_last_q || !bus.seq_wrdata_en_i);

`ifdef PARTIAL_WR_STATS_EN
  logic             keep_q;
  logic [CNT_W-1:0] bursts_q, masked_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      keep_q   <= 1'b1;
      bursts_q <= '0;
      masked_q <= '0;
    end else begin
      keep_q <= keep;
      if (stat_clr_i) begin
        bursts_q <= '0;
        masked_q <= '0;
      end else begin
        if (burst_done_o && !(&bursts_q))          bursts_q <= bursts_q + 1'b1;
        if (out_en_q && !keep_q && !(&masked_q))   masked_q <= masked_q + 1'b1;
      end
    end
  end

  assign stat_bursts_o = bursts_q;
  assign stat_masked_o = masked_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr_i;
  assign stat_bursts_o   = '0;
  assign stat_masked_o   = '0;
`endif

endmodule

// File: tb/tb_ddr3_partial_wr_shaper.sv
// ---------------------------------------------------------------------------
// tb_ddr3_partial_wr_shaper
// Directed bench for ddr3_partial_wr_shaper (DATA_W=32, MAX_BEATS=8).
// Inputs change on the falling edge; outputs are examined 1 ns later.
// ---------------------------------------------------------------------------
module tb_ddr3_partial_wr_shaper;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cfg_mode;
  logic [2:0]  cfg_start;
  logic [3:0]  cfg_len;
  logic [7:0]  cfg_bitmap;
  logic        busy, burst_done, stat_clr;
  logic [15:0] stat_bursts, stat_masked;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ddr3_partial_wr_shaper_if #(.DATA_W(32)) bus ();

  ddr3_partial_wr_shaper #(.DATA_W(32), .MAX_BEATS(8), .CNT_W(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cfg_mode_i   (cfg_mode),
    .cfg_start_i  (cfg_start),
    .cfg_len_i    (cfg_len),
    .cfg_bitmap_i (cfg_bitmap),
    .bus          (bus),
    .busy_o       (busy),
    .burst_done_o (burst_done),
    .stat_clr_i   (stat_clr),
    .stat_bursts_o(stat_bursts),
    .stat_masked_o(stat_masked)
  );

  task automatic chk_out(input string tag, input logic e_en, input logic [3:0] e_m,
                         input logic e_done, input logic [31:0] e_d);
    checks++;
    assert ({bus.dfi_wrdata_en_o, busy, bus.dfi_wrdata_mask_o, burst_done, bus.dfi_wrdata_o}
            === {e_en, e_en, e_m, e_done, e_d})
    else begin
      errors++;
      $error("FAIL %s got en=%b busy=%b mask=%h done=%b data=%h exp en=%b busy=%b mask=%h done=%b data=%h",
             tag, bus.dfi_wrdata_en_o, busy, bus.dfi_wrdata_mask_o, burst_done, bus.dfi_wrdata_o,
             e_en, e_en, e_m, e_done, e_d);
    end
  endtask

  task automatic chk_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, obs, exp);
    end
  endtask

  // Drives n enabled beats then one idle cycle; km is the hand-derived keep
  // map per beat index, sm the sequencer mask. At step chg_at, cfg_len is
  // changed to chg_len (mid-burst config change).
  task automatic burst(input string tag, input int n, input logic [7:0] km,
                       input logic [3:0] sm, input logic [31:0] base,
                       input int chg_at, input logic [3:0] chg_len);
    for (int i = 0; i <= n; i++) begin
      if (i == chg_at) cfg_len = chg_len;
      @(negedge clk);
      bus.seq_wrdata_en_i   = (i < n);
      bus.seq_wrdata_i      = base + 32'(i);
      bus.seq_wrdata_mask_i = sm;
      #1;
      if (i > 0) begin
        int b;
        b = (i - 1) % 8;
        chk_out(tag, 1'b1, km[b] ? sm : 4'hF, (i == n) || (b == 7), base + 32'(i - 1));
      end
    end
    @(negedge clk);
    bus.seq_wrdata_en_i = 1'b0;
    bus.seq_wrdata_i    = 32'hDEAD_0000;
    #1;
    chk_out({tag, "_idle"}, 1'b0, 4'hF, 1'b0, base + 32'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cfg_mode = 2'd0; cfg_start = 3'd0; cfg_len = 4'd0; cfg_bitmap = 8'h00;
    stat_clr = 1'b0;
    bus.seq_wrdata_en_i = 1'b0; bus.seq_wrdata_i = 32'h0; bus.seq_wrdata_mask_i = 4'h0;
    #3;
    chk_out("reset", 1'b0, 4'hF, 1'b0, 32'h0);
    chk_val("reset_bursts", stat_bursts, 16'd0);
    chk_val("reset_masked", stat_masked, 16'd0);
    @(negedge clk); rst = 1'b0;

    // 1: pass mode, full burst
    cfg_mode = 2'd0;
    burst("t1_pass", 8, 8'hFF, 4'h0, 32'hA000_0000, -1, 4'd0);
    // short burst, head len=0 -> every beat masked
    cfg_mode = 2'd1; cfg_len = 4'd0;
    burst("t1_len0_short", 3, 8'h00, 4'h0, 32'hB000_0000, -1, 4'd0);
    // 2: head len=3, sequencer mask ORed on kept beats
    cfg_len = 4'd3;
    burst("t2_head", 8, 8'h07, 4'h1, 32'hC000_0000, -1, 4'd0);

    @(negedge clk); stat_clr = 1'b1;
    @(negedge clk); stat_clr = 1'b0;
    // 3: window start=6 len=4 clipped -> beats 6,7 kept
    cfg_mode = 2'd2; cfg_start = 3'd6; cfg_len = 4'd4;
    burst("t3_window", 8, 8'hC0, 4'h0, 32'hD000_0000, -1, 4'd0);
`ifdef PARTIAL_WR_STATS_EN
    chk_val("t3_stat_masked", stat_masked, 16'd6);
    chk_val("t3_stat_bursts", stat_bursts, 16'd1);
`else
    chk_val("t3_stat_masked", stat_masked, 16'd0);
    chk_val("t3_stat_bursts", stat_bursts, 16'd0);
`endif

    // 4: bitmap A5, 16 back-to-back beats -> two bursts
    cfg_mode = 2'd3; cfg_bitmap = 8'hA5;
    burst("t4_bitmap", 16, 8'hA5, 4'h4, 32'hE000_0000, -1, 4'd0);

    // 5: head len=2, len changed to 8 at beat 3 -> ignored until next burst
    cfg_mode = 2'd1; cfg_len = 4'd2;
    burst("t5_cur", 8, 8'h03, 4'h0, 32'hF000_0000, 3, 4'd8);
    burst("t5_next", 8, 8'hFF, 4'h0, 32'hF100_0000, -1, 4'd0);

    // 6: reset at beat 4 of a pass-mode burst
    cfg_mode = 2'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.seq_wrdata_en_i = 1'b1; bus.seq_wrdata_i = 32'h6000_0000 + 32'(i);
      bus.seq_wrdata_mask_i = 4'h0;
      #1;
      if (i > 0) chk_out("t6_pre", 1'b1, 4'h0, 1'b0, 32'h6000_0000 + 32'(i - 1));
    end
    @(posedge clk); #2;
    rst = 1'b1; #1;
    chk_out("t6_rst", 1'b0, 4'hF, 1'b0, 32'h0);
    @(negedge clk);
    rst = 1'b0; bus.seq_wrdata_en_i = 1'b0;
    // head len=1: only beat 0 kept, proving the index restarted at 0
    cfg_mode = 2'd1; cfg_len = 4'd1;
    burst("t6_post", 2, 8'h01, 4'h0, 32'h6100_0000, -1, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
